// File: rtl/assign_op_pkg.sv
// Shared types for the accumulator: operation codes and the divide-sequencing FSM states.
package assign_op_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_DIV   = 4'd4,
    OP_MOD   = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_XOR   = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_ASHL  = 4'd11,
    OP_ASHR  = 4'd12,
    OP_NOP13 = 4'd13,
    OP_NOP14 = 4'd14,
    OP_NOP15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/assign_op_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, WIDTH iterations total.
module assign_op_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    remaining;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH:0]   trial, diff;

  // The first iteration runs on the start edge itself, straight from the operands.
  always_comb begin
    src_rem = rem_q;
    src_quo = quo_q;
    src_dvs = dvs_q;
    if (start && !busy) begin
      src_rem = '0;
      src_quo = dividend;
      src_dvs = divisor;
    end
    trial = {src_rem, src_quo[WIDTH-1]};
    diff  = trial - {1'b0, src_dvs};
    if (trial >= {1'b0, src_dvs}) begin
      step_rem = diff[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = trial[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start && !busy) begin
        rem_q     <= step_rem;
        quo_q     <= step_quo;
        dvs_q     <= divisor;
        remaining <= CW'(WIDTH - 1);
        busy      <= 1'b1;
      end else if (busy) begin
        rem_q     <= step_rem;
        quo_q     <= step_quo;
        remaining <= remaining - 1'b1;
        if (remaining == CW'(1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/assign_op_accumulator.sv
// Accumulator applying one operation per cycle to acc; DIV/MOD go through the iterative divider.
module assign_op_accumulator
  import assign_op_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             done,
  output logic             div_by_zero
);

  localparam int               SHW       = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_LIM = WIDTH'(WIDTH);

  state_e           state, state_nxt;
  op_e              op;
  logic             accept, is_div_op, div_start, is_mod;
  logic             shift_big;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             div_busy, div_valid;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign op        = op_e'(op_code);
  assign accept    = op_valid && op_ready;
  assign is_div_op = (op == OP_DIV) || (op == OP_MOD);
  assign shift_big = (operand >= WIDTH_LIM);
  assign shamt     = operand[SHW-1:0];

  always_comb begin
    alu_res = acc;
    case (op)
      OP_LOAD: alu_res = operand;
      OP_ADD:  alu_res = acc + operand;
      OP_SUB:  alu_res = acc - operand;
      OP_MUL:  alu_res = acc * operand;
      OP_AND:  alu_res = acc & operand;
      OP_OR:   alu_res = acc | operand;
      OP_XOR:  alu_res = acc ^ operand;
      OP_SHL, OP_ASHL: alu_res = shift_big ? '0 : (acc << shamt);
      OP_SHR:  alu_res = shift_big ? '0 : (acc >> shamt);
      OP_ASHR: alu_res = shift_big ? {WIDTH{acc[WIDTH-1]}} : WIDTH'($signed(acc) >>> shamt);
      default: alu_res = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    div_start = 1'b0;
    case (state)
      ST_IDLE: begin
        op_ready  = !div_busy;
        div_start = accept && is_div_op && (operand != '0);
        if (div_start) state_nxt = ST_DIVIDE;
      end
      ST_DIVIDE: if (div_valid) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // acc keeps its pre-divide value until the FINISH->IDLE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= RESET_VALUE;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      is_mod      <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == ST_IDLE && accept) begin
        if (is_div_op) begin
          if (operand == '0) begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
          end else begin
            is_mod <= (op == OP_MOD);
          end
        end else begin
          acc  <= alu_res;
          done <= 1'b1;
        end
      end else if (state == ST_FINISH) begin
        acc  <= is_mod ? div_rem : div_quo;
        done <= 1'b1;
      end
    end
  end

  assign_op_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (acc),
    .divisor   (operand),
    .busy      (div_busy),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

endmodule

// File: tb/tb_assign_op_accumulator.sv
// Bench for assign_op_accumulator: directed vector table, reset corner cases, and random ops against a reference model.
module tb_assign_op_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [31:0] operand;
  logic [31:0] acc;
  logic        done;
  logic        div_by_zero;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign_op_accumulator #(.WIDTH(32), .RESET_VALUE('0)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .operand     (operand),
    .acc         (acc),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [3:0]  code;
    logic [31:0] opnd;
    logic [31:0] exp_acc;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model built from the arithmetic definition of each operation.
  function automatic logic [31:0] ref_op(input logic [31:0] a, input int code, input logic [31:0] b);
    longint unsigned ua = a;
    longint          sa = longint'($signed(a));
    longint unsigned p  = 64'd1 << ((b > 32) ? 32 : b);
    longint unsigned r;
    case (code)
      0:  r = b;
      1:  r = ua + b;
      2:  r = ua - b;
      3:  r = ua * b;
      4:  r = (b == 0) ? ua : ua / b;
      5:  r = (b == 0) ? ua : ua % b;
      6:  r = ua & b;
      7:  r = ua | b;
      8:  r = ua ^ b;
      9, 11: r = ua * p;
      10: r = ua / p;
      12: r = (sa >= 0) ? longint'(sa / longint'(p)) : -((-sa + longint'(p) - 1) / longint'(p));
      default: r = ua;
    endcase
    return r[31:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 of the done sample (or the timeout).
  task automatic run_op(input logic [3:0] code, input logic [31:0] opnd, input logic [31:0] exp_acc,
                        input logic exp_dbz, input int exp_lat, input bit hold, input string tag);
    int lat, low;
    check({tag, " ready"}, op_ready, 1);
    op_valid = 1'b1; op_code = code; operand = opnd;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 1;
    low = (!op_ready && !done) ? 1 : 0;
    while (!done && lat < 80) begin
      if (hold) begin
        op_valid = 1'b1; op_code = 4'($urandom); operand = $urandom;
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      lat++;
      if (!op_ready && !done) low++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " acc"}, acc, exp_acc);
    check({tag, " dbz"}, div_by_zero, exp_dbz);
    check({tag, " ready_low"}, low, exp_lat - 1);
  endtask

  initial begin
    int ndone;
    logic [31:0] m;
    rst = 1'b1; op_valid = 1'b0; op_code = '0; operand = '0;

    repeat (3) @(posedge clk); #1;
    check("reset acc", acc, 0);
    check("reset done", done, 0);
    check("reset dbz", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready after reset", op_ready, 1);

    // ADD 2 then SUB 2 back-to-back
    op_valid = 1'b1; op_code = 4'd1; operand = 32'd2;
    @(posedge clk); #1;
    check("b2b add acc", acc, 2);
    check("b2b add done", done, 1);
    check("b2b ready", op_ready, 1);
    op_code = 4'd2; operand = 32'd2;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("b2b sub acc", acc, 0);
    check("b2b sub done", done, 1);
    @(posedge clk); #1;
    check("b2b done drops", done, 0);

    vecs.push_back('{4'd0,  32'd100,        32'd100,        1'b0, 1});
    vecs.push_back('{4'd4,  32'd7,          32'd14,         1'b0, 34});
    vecs.push_back('{4'd0,  32'd100,        32'd100,        1'b0, 1});
    vecs.push_back('{4'd5,  32'd17,         32'd15,         1'b0, 34});
    vecs.push_back('{4'd0,  32'd55,         32'd55,         1'b0, 1});
    vecs.push_back('{4'd4,  32'd0,          32'd55,         1'b1, 1});
    vecs.push_back('{4'd0,  32'h8000_0000,  32'h8000_0000,  1'b0, 1});
    vecs.push_back('{4'd12, 32'd14,         32'hFFFE_0000,  1'b0, 1});
    vecs.push_back('{4'd0,  32'h8000_0000,  32'h8000_0000,  1'b0, 1});
    vecs.push_back('{4'd10, 32'd14,         32'h0002_0000,  1'b0, 1});
    vecs.push_back('{4'd9,  32'd40,         32'h0,          1'b0, 1});
    vecs.push_back('{4'd0,  32'h1_0000,     32'h1_0000,     1'b0, 1});
    vecs.push_back('{4'd3,  32'h1_0000,     32'h0,          1'b0, 1});
    vecs.push_back('{4'd0,  32'hF0,         32'hF0,         1'b0, 1});
    vecs.push_back('{4'd13, 32'h1234,       32'hF0,         1'b0, 1});
    vecs.push_back('{4'd8,  32'hFF,         32'h0F,         1'b0, 1});
    vecs.push_back('{4'd7,  32'h100,        32'h10F,        1'b0, 1});
    vecs.push_back('{4'd6,  32'h1F0,        32'h100,        1'b0, 1});
    vecs.push_back('{4'd11, 32'd4,          32'h1000,       1'b0, 1});
    vecs.push_back('{4'd12, 32'd32,         32'h0,          1'b0, 1});
    vecs.push_back('{4'd0,  32'h8000_0001,  32'h8000_0001,  1'b0, 1});
    vecs.push_back('{4'd12, 32'd40,         32'hFFFF_FFFF,  1'b0, 1});
    vecs.push_back('{4'd10, 32'd32,         32'h0,          1'b0, 1});
    vecs.push_back('{4'd5,  32'd0,          32'h0,          1'b1, 1});
    vecs.push_back('{4'd0,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1});
    vecs.push_back('{4'd1,  32'd3,          32'h2,          1'b0, 1});
    vecs.push_back('{4'd2,  32'd5,          32'hFFFF_FFFD,  1'b0, 1});
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].code, vecs[i].opnd, vecs[i].exp_acc, vecs[i].exp_dbz, vecs[i].exp_lat, 1'b0,
             $sformatf("vec%0d", i));

    // op_valid held with random ops throughout a divide
    run_op(4'd0, 32'd1000, 32'd1000, 1'b0, 1, 1'b0, "hold load");
    run_op(4'd4, 32'd3, 32'd333, 1'b0, 34, 1'b1, "hold div");
    @(posedge clk); #1;
    check("hold after done", done, 0);

    // reset at cycle 10 of a divide
    run_op(4'd0, 32'd1000, 32'd1000, 1'b0, 1, 1'b0, "abort load");
    op_valid = 1'b1; op_code = 4'd4; operand = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clk); #1;
    check("abort busy", op_ready, 0);
    rst = 1'b1;
    #1;
    check("abort acc immediate", acc, 0);
    check("abort done", done, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort ready", op_ready, 1);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    check("abort acc stays", acc, 0);

    m = 32'd0;
    for (int i = 0; i < 60; i++) begin
      int          c;
      logic [31:0] b;
      logic [31:0] e;
      bit          isdiv;
      c = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 40);
        2: b = 32'd0;
        default: b = $urandom_range(1, 1000);
      endcase
      isdiv = (c == 4 || c == 5);
      e = ref_op(m, c, b);
      run_op(4'(c), b, e, isdiv && b == 0, (isdiv && b != 0) ? 34 : 1, bit'($urandom_range(0, 1)),
             $sformatf("rnd%0d op%0d", i, c));
      m = e;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/assign_op_accumulator.md
ASSIGN_OP_ACCUMULATOR -- requirements
Module: assign_op_accumulator

Interface
REQ-001 Parameter WIDTH, default 32: accumulator and operand width in bits; legal range 8..64.
REQ-002 Parameter RESET_VALUE, default '0: accumulator value loaded on reset.
REQ-003 Port clk  input  1: single clock, all state on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port op_valid  input  1: operation request.
REQ-006 Port op_ready  output  1: block can accept an operation this cycle.
REQ-007 Port op_code  input  4: operation select, type op_e.
REQ-008 Port operand  input  WIDTH: right-hand operand, unsigned except where stated.
REQ-009 Port acc  output  WIDTH: registered accumulator value.
REQ-010 Port done  output  1: one-cycle pulse when an accepted operation has updated acc.
REQ-011 Port div_by_zero  output  1: one-cycle pulse, coincident with done, for DIV/MOD with operand==0.

Function
REQ-012 Operation accepted on a rising edge where op_valid&&op_ready.
REQ-013 op_code map: 0 LOAD (acc=operand), 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD, 6 AND, 7 OR, 8 XOR, 9 SHL, 10 SHR, 11 ASHL, 12 ASHR, 13-15 NOP.
REQ-014 ADD/SUB/MUL: result truncated to low WIDTH bits, wrap-around, no overflow flag.
REQ-015 Shifts: amount is the full operand value; amount>=WIDTH gives 0 for SHL/SHR/ASHL and WIDTH copies of acc[WIDTH-1] for ASHR.
REQ-016 ASHL identical to SHL; ASHR treats acc as signed two's complement.
REQ-017 Single-cycle ops (all except DIV/MOD): acc updated on the accepting edge; done high the following cycle; op_ready stays 1 (back-to-back acceptance every cycle).
REQ-018 NOP: acc unchanged, done still pulses.
REQ-019 DIV/MOD unsigned, computed by an iterative restoring divider, one quotient bit per cycle.
REQ-020 FSM states IDLE, DIVIDE, FINISH; IDLE->DIVIDE on accepted DIV/MOD with operand!=0; DIVIDE->FINISH after WIDTH iterations; FINISH->IDLE unconditionally.
REQ-021 op_ready=1 only in IDLE; in DIVIDE/FINISH op_valid ignored.
REQ-022 acc takes quotient (DIV) or remainder (MOD) on the FINISH->IDLE edge; done high the cycle after: accept-to-done latency WIDTH+2 cycles.
REQ-023 DIV/MOD with operand==0: no DIVIDE entry, acc unchanged, done and div_by_zero pulse the next cycle, op_ready stays 1.
REQ-024 acc visible externally holds its pre-divide value throughout DIVIDE/FINISH.
REQ-025 done and div_by_zero are 0 in all other cycles.

Reset
REQ-026 Asserting rst forces immediately: acc=RESET_VALUE, state=IDLE, done=0, div_by_zero=0, divider datapath cleared.
REQ-027 rst during DIVIDE/FINISH aborts the operation; no done for it.
REQ-028 op_ready=1 from the first edge after rst deasserts.

Structure
REQ-029 Package assign_op_pkg holds op_e enum (4-bit) and the FSM state enum.
REQ-030 Iterative divider is one sub-module assign_op_divider (start, dividend, divisor, busy, quotient, remainder, valid), parameterised by WIDTH.
REQ-031 All arithmetic in the top-level uses the package enum; no literal opcodes.

Verification (WIDTH=32, RESET_VALUE=0)
REQ-032 Reset; ADD 2 then SUB 2 back-to-back -> acc 2 then 0, done pulses two consecutive cycles.
REQ-033 LOAD 100, DIV 7 -> op_ready low 33 cycles, acc=14, done 34 cycles after accept; LOAD 100, MOD 17 -> acc=15.
REQ-034 LOAD 55, DIV 0 -> acc stays 55, done and div_by_zero pulse together next cycle, no busy period.
REQ-035 LOAD 0x8000_0000, ASHR 14 -> 0xFFFE_0000; LOAD 0x8000_0000, SHR 14 -> 0x0002_0000; SHL 40 -> 0; LOAD 0x10000, MUL 0x10000 -> 0.
REQ-036 LOAD 1000, DIV 3, assert rst at cycle 10 of DIVIDE -> acc=0 immediately, no done, op_ready=1 one edge after release.
REQ-037 op_valid held high with varying op_code during DIVIDE -> none accepted; acc reflects only the divide result.
